// File: rtl/zigbee_phy_pkg.sv
// rtl/zigbee_phy_pkg.sv - shared PPDU framer states, frame constants and CRC-16 step
package zigbee_phy_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SFD,
        PHR,
        PAY,
        FCS,
        DONE
    } state_t;

    localparam int          PREAMBLE_SYMS = 8;
    localparam logic [7:0]  SFD_BYTE      = 8'hA7;
    localparam int          MAX_LEN       = 127;
    localparam logic [15:0] CRC_POLY      = 16'h1021;

    localparam logic [2:0]  PRE_LAST      = 3'(PREAMBLE_SYMS - 1);
    localparam logic [6:0]  FCS_MAX_LEN   = 7'(MAX_LEN - 2);

    // One byte through the x^16+x^12+x^5+1 register, data bit 0 first.
    function automatic logic [15:0] crc_byte(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0};
            if (fb) begin
                c = c ^ CRC_POLY;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc16_802154.sv
// rtl/crc16_802154.sv - byte-wide CRC-16 accumulator with synchronous clear
module crc16_802154
    import zigbee_phy_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    // Clear has priority so a new frame always starts from zero.
    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = '0;
        end else if (en) begin
            crc_d = crc_byte(crc_q, data);
        end
    end

    // CRC register.
    always_ff @(posedge clk) begin
        crc_q <= crc_d;
    end

    assign crc = crc_q;

endmodule

// File: rtl/ppdu_symbol_framer.sv
// rtl/ppdu_symbol_framer.sv - PPDU to 4-bit symbol framer; PPDU_FCS_EN adds the CRC-16 FCS trailer
module ppdu_symbol_framer
    import zigbee_phy_pkg::*;
(
    input  logic       inClk,
    input  logic       inRstn,
    input  logic       inStart,
    input  logic [6:0] inLength,
    input  logic [7:0] inByte,
    input  logic       inByteValid,
    output logic       outByteReady,
    output logic [3:0] outSym,
    output logic       outSymValid,
    input  logic       inSymReady,
    output logic       outBusy,
    output logic       outDone,
    output logic       outErr
);

    state_t     state_q,     state_d;
    logic [2:0] sym_cnt_q,   sym_cnt_d;
    logic [6:0] len_q,       len_d;
    logic [6:0] fetch_cnt_q, fetch_cnt_d;
    logic [7:0] byte_q,      byte_d;
    logic       full_q,      full_d;
    logic       nib_q,       nib_d;
    logic       busy_q,      busy_d;
    logic       done_q,      done_d;
    logic       err_q,       err_d;

    logic [3:0] sym;
    logic       sym_valid;
    logic       byte_ready;
    logic       sym_xfer;
    logic       byte_xfer;
    logic       len_ok;
    logic [6:0] phr_len;

`ifdef PPDU_FCS_EN
    logic [15:0] crc;

    assign phr_len = len_q + 7'd2;
    assign len_ok  = (inLength != 7'd0) && (inLength <= FCS_MAX_LEN);

    crc16_802154 u_crc (
        .clk  (inClk),
        .clr  (!inRstn || ((state_q == IDLE) && inStart)),
        .en   (byte_xfer),
        .data (inByte),
        .crc  (crc)
    );
`else
    assign phr_len = len_q;
    assign len_ok  = (inLength != 7'd0);
`endif

    // Symbol and byte-handshake outputs decoded purely from registered state.
    always_comb begin
        sym        = 4'h0;
        sym_valid  = 1'b0;
        byte_ready = 1'b0;
        case (state_q)
            PRE: begin
                sym_valid = 1'b1;
            end
            SFD: begin
                sym_valid = 1'b1;
                sym       = sym_cnt_q[0] ? SFD_BYTE[7:4] : SFD_BYTE[3:0];
            end
            PHR: begin
                sym_valid = 1'b1;
                sym       = sym_cnt_q[0] ? {1'b0, phr_len[6:4]} : phr_len[3:0];
            end
            PAY: begin
                sym_valid  = full_q;
                sym        = nib_q ? byte_q[7:4] : byte_q[3:0];
                byte_ready = !full_q && (fetch_cnt_q != len_q);
            end
`ifdef PPDU_FCS_EN
            FCS: begin
                sym_valid = 1'b1;
                case (sym_cnt_q[1:0])
                    2'd0:    sym = crc[3:0];
                    2'd1:    sym = crc[7:4];
                    2'd2:    sym = crc[11:8];
                    default: sym = crc[15:12];
                endcase
            end
`endif
            default: begin
                sym = 4'h0;
            end
        endcase
    end

    assign sym_xfer  = sym_valid && inSymReady;
    assign byte_xfer = byte_ready && inByteValid;

    // Frame sequencing: next state, counters, holding register and status pulses.
    always_comb begin
        state_d     = state_q;
        sym_cnt_d   = sym_cnt_q;
        len_d       = len_q;
        fetch_cnt_d = fetch_cnt_q;
        byte_d      = byte_q;
        full_d      = full_q;
        nib_d       = nib_q;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (inStart) begin
                    if (len_ok) begin
                        len_d       = inLength;
                        state_d     = PRE;
                        sym_cnt_d   = 3'd0;
                        fetch_cnt_d = 7'd0;
                        full_d      = 1'b0;
                        nib_d       = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            PRE: begin
                if (sym_xfer) begin
                    if (sym_cnt_q == PRE_LAST) begin
                        state_d   = SFD;
                        sym_cnt_d = 3'd0;
                    end else begin
                        sym_cnt_d = sym_cnt_q + 3'd1;
                    end
                end
            end
            SFD: begin
                if (sym_xfer) begin
                    if (sym_cnt_q[0]) begin
                        state_d   = PHR;
                        sym_cnt_d = 3'd0;
                    end else begin
                        sym_cnt_d = sym_cnt_q + 3'd1;
                    end
                end
            end
            PHR: begin
                if (sym_xfer) begin
                    if (sym_cnt_q[0]) begin
                        state_d   = PAY;
                        sym_cnt_d = 3'd0;
                    end else begin
                        sym_cnt_d = sym_cnt_q + 3'd1;
                    end
                end
            end
            PAY: begin
                // Accept and emit never coincide: ready needs an empty register, valid a full one.
                if (byte_xfer) begin
                    byte_d      = inByte;
                    full_d      = 1'b1;
                    fetch_cnt_d = fetch_cnt_q + 7'd1;
                end
                if (sym_xfer) begin
                    if (!nib_q) begin
                        nib_d = 1'b1;
                    end else begin
                        nib_d  = 1'b0;
                        full_d = 1'b0;
                        if (fetch_cnt_q == len_q) begin
`ifdef PPDU_FCS_EN
                            state_d   = FCS;
                            sym_cnt_d = 3'd0;
`else
                            state_d   = DONE;
`endif
                        end
                    end
                end
            end
`ifdef PPDU_FCS_EN
            FCS: begin
                if (sym_xfer) begin
                    if (sym_cnt_q[1:0] == 2'd3) begin
                        state_d = DONE;
                    end else begin
                        sym_cnt_d = sym_cnt_q + 3'd1;
                    end
                end
            end
`endif
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE) && (state_d != DONE);
        done_d = (state_d == DONE);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge inClk) begin
        if (!inRstn) begin
            state_q     <= IDLE;
            sym_cnt_q   <= 3'd0;
            len_q       <= 7'd0;
            fetch_cnt_q <= 7'd0;
            byte_q      <= 8'd0;
            full_q      <= 1'b0;
            nib_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sym_cnt_q   <= sym_cnt_d;
            len_q       <= len_d;
            fetch_cnt_q <= fetch_cnt_d;
            byte_q      <= byte_d;
            full_q      <= full_d;
            nib_q       <= nib_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign outSym       = sym;
    assign outSymValid  = sym_valid;
    assign outByteReady = byte_ready;
    assign outBusy      = busy_q;
    assign outDone      = done_q;
    assign outErr       = err_q;

endmodule

// File: tb/tb_ppdu_symbol_framer.sv
// tb/tb_ppdu_symbol_framer.sv - directed self-checking bench for ppdu_symbol_framer
module tb_ppdu_symbol_framer;

`ifdef PPDU_FCS_EN
    localparam int FCS_SYMS  = 4;
    localparam int LEN_LEGAL = 125;
`else
    localparam int FCS_SYMS  = 0;
    localparam int LEN_LEGAL = 127;
`endif

    logic       inClk = 1'b0;
    logic       inRstn = 1'b0;
    logic       inStart = 1'b0;
    logic [6:0] inLength = 7'd0;
    logic [7:0] inByte = 8'd0;
    logic       inByteValid = 1'b0;
    logic       inSymReady = 1'b1;
    logic       outByteReady;
    logic [3:0] outSym;
    logic       outSymValid;
    logic       outBusy;
    logic       outDone;
    logic       outErr;

    int checks = 0;
    int failures = 0;

    logic [3:0] got[$];
    logic [3:0] exp[$];
    int         done_cnt = 0;
    int         err_cnt = 0;
    int         stab_viol = 0;
    bit         feed_to = 1'b0;
    bit         bp_stop = 1'b0;
    logic       prev_stall = 1'b0;
    logic [3:0] prev_sym = 4'h0;

    ppdu_symbol_framer dut (
        .inClk        (inClk),
        .inRstn       (inRstn),
        .inStart      (inStart),
        .inLength     (inLength),
        .inByte       (inByte),
        .inByteValid  (inByteValid),
        .outByteReady (outByteReady),
        .outSym       (outSym),
        .outSymValid  (outSymValid),
        .inSymReady   (inSymReady),
        .outBusy      (outBusy),
        .outDone      (outDone),
        .outErr       (outErr)
    );

    always #5 inClk = ~inClk;

    always @(negedge inClk) begin
        if (prev_stall && (!outSymValid || outSym !== prev_sym)) stab_viol++;
        if (outSymValid && inSymReady) got.push_back(outSym);
        if (outDone) done_cnt++;
        if (outErr) err_cnt++;
        prev_stall = outSymValid && !inSymReady;
        prev_sym   = outSym;
    end

`ifdef PPDU_FCS_EN
    function automatic logic [15:0] model_crc(input logic [7:0] b[$]);
        logic [15:0] c;
        logic        fb;
        c = 16'h0000;
        foreach (b[k]) begin
            for (int i = 0; i < 8; i++) begin
                fb = c[15] ^ b[k][i];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
        end
        return c;
    endfunction
`endif

    function automatic void build_exp(input int len, input logic [7:0] b[$]);
        logic [6:0] phr;
        exp.delete();
        for (int i = 0; i < 8; i++) exp.push_back(4'h0);
        exp.push_back(4'h7);
        exp.push_back(4'hA);
        phr = 7'(len + (FCS_SYMS / 2));
        exp.push_back(phr[3:0]);
        exp.push_back({1'b0, phr[6:4]});
        foreach (b[k]) begin
            exp.push_back(b[k][3:0]);
            exp.push_back(b[k][7:4]);
        end
`ifdef PPDU_FCS_EN
        begin
            logic [15:0] c;
            c = model_crc(b);
            exp.push_back(c[3:0]);
            exp.push_back(c[7:4]);
            exp.push_back(c[11:8]);
            exp.push_back(c[15:12]);
        end
`endif
    endfunction

    task automatic clear_mon();
        got.delete();
        done_cnt  = 0;
        err_cnt   = 0;
        stab_viol = 0;
        feed_to   = 1'b0;
    endtask

    task automatic start_frame(input int len);
        @(posedge inClk); #1;
        inStart  = 1'b1;
        inLength = 7'(len);
        @(posedge inClk); #1;
        inStart  = 1'b0;
    endtask

    task automatic feed_bytes(input logic [7:0] b[$], input int gap_idx, input int gap);
        for (int i = 0; i < b.size(); i++) begin
            int n;
            if (i == gap_idx) begin
                repeat (gap) @(posedge inClk);
                #1;
            end
            inByte      = b[i];
            inByteValid = 1'b1;
            n = 0;
            @(negedge inClk);
            while (!outByteReady && n < 500) begin
                n++;
                @(negedge inClk);
            end
            if (!outByteReady) feed_to = 1'b1;
            @(posedge inClk); #1;
            inByteValid = 1'b0;
        end
    endtask

    task automatic wait_done(input int budget, output int cycles);
        cycles = -1;
        for (int n = 1; n <= budget; n++) begin
            @(negedge inClk);
            if (outDone) begin
                cycles = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        inRstn = 1'b0;
        repeat (3) @(posedge inClk);
        @(negedge inClk);
        checks++; if (outSymValid !== 1'b0)  begin failures++; $display("FAIL reset_sym_valid got=%b exp=0", outSymValid); end
        checks++; if (outSym !== 4'h0)       begin failures++; $display("FAIL reset_sym got=%h exp=0", outSym); end
        checks++; if (outByteReady !== 1'b0) begin failures++; $display("FAIL reset_byte_ready got=%b exp=0", outByteReady); end
        checks++; if (outBusy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b exp=0", outBusy); end
        checks++; if (outDone !== 1'b0)      begin failures++; $display("FAIL reset_done got=%b exp=0", outDone); end
        checks++; if (outErr !== 1'b0)       begin failures++; $display("FAIL reset_err got=%b exp=0", outErr); end
        @(posedge inClk); #1;
        inRstn = 1'b1;
    endtask

    task automatic test_basic_frame(input string tag);
        logic [7:0] bq[$];
        int         cyc;
        bq = '{8'h3C};
        build_exp(1, bq);
        clear_mon();
        start_frame(1);
        checks++; if (outBusy !== 1'b1) begin failures++; $display("FAIL %s_busy_on got=%b exp=1", tag, outBusy); end
        fork
            feed_bytes(bq, -1, 0);
            wait_done(300, cyc);
        join
        checks++; if (cyc !== 16 + FCS_SYMS) begin failures++; $display("FAIL %s_done_latency got=%0d exp=%0d", tag, cyc, 16 + FCS_SYMS); end
        checks++; if (outBusy !== 1'b0) begin failures++; $display("FAIL %s_busy_at_done got=%b exp=0", tag, outBusy); end
        checks++; if (feed_to !== 1'b0) begin failures++; $display("FAIL %s_byte_timeout got=%b exp=0", tag, feed_to); end
        checks++; if (got.size() != exp.size()) begin failures++; $display("FAIL %s_count got=%0d exp=%0d", tag, got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL %s_sym[%0d] got=%h exp=%h", tag, i, got[i], exp[i]); end
        end
        @(negedge inClk);
        checks++; if (outDone !== 1'b0) begin failures++; $display("FAIL %s_done_width got=%b exp=0", tag, outDone); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL %s_done_count got=%0d exp=1", tag, done_cnt); end
    endtask

    task automatic test_backpressure();
        logic [7:0] bq[$];
        int         cyc;
        bq = '{8'h3C};
        build_exp(1, bq);
        clear_mon();
        bp_stop = 1'b0;
        inSymReady = 1'b0;
        start_frame(1);
        fork
            while (!bp_stop) begin
                @(posedge inClk); #1;
                inSymReady = ~inSymReady;
            end
            feed_bytes(bq, -1, 0);
            begin
                wait_done(400, cyc);
                bp_stop = 1'b1;
            end
        join
        inSymReady = 1'b1;
        checks++; if (cyc < 0) begin failures++; $display("FAIL bp_done_timeout got=%0d exp=done", cyc); end
        checks++; if (stab_viol !== 0) begin failures++; $display("FAIL bp_stall_stability got=%0d exp=0", stab_viol); end
        checks++; if (got.size() != exp.size()) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL bp_sym[%0d] got=%h exp=%h", i, got[i], exp[i]); end
        end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL bp_done_count got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_underrun();
        logic [7:0] bq[$];
        int         cyc;
        int         gsz;
        bq = '{8'h5A, 8'hE1};
        build_exp(2, bq);
        clear_mon();
        gsz = -1;
        start_frame(2);
        fork
            feed_bytes(bq, 1, 10);
            begin
                int n;
                n = 0;
                while (got.size() < 14 && n < 300) begin
                    n++;
                    @(negedge inClk);
                end
                repeat (3) @(negedge inClk);
                checks++; if (outSymValid !== 1'b0) begin failures++; $display("FAIL underrun_valid got=%b exp=0", outSymValid); end
                checks++; if (outByteReady !== 1'b1) begin failures++; $display("FAIL underrun_byte_ready got=%b exp=1", outByteReady); end
            end
            begin
                wait_done(400, cyc);
                gsz = got.size();
            end
        join
        checks++; if (cyc < 0) begin failures++; $display("FAIL underrun_done_timeout got=%0d exp=done", cyc); end
        checks++; if (gsz != 16 + FCS_SYMS) begin failures++; $display("FAIL underrun_syms_at_done got=%0d exp=%0d", gsz, 16 + FCS_SYMS); end
        checks++; if (got.size() != exp.size()) begin failures++; $display("FAIL underrun_count got=%0d exp=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL underrun_sym[%0d] got=%h exp=%h", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_reject();
        clear_mon();
        start_frame(0);
        checks++; if (outErr !== 1'b1)  begin failures++; $display("FAIL reject0_err got=%b exp=1", outErr); end
        checks++; if (outBusy !== 1'b0) begin failures++; $display("FAIL reject0_busy got=%b exp=0", outBusy); end
        @(posedge inClk); #1;
        checks++; if (outErr !== 1'b0)  begin failures++; $display("FAIL reject0_err_width got=%b exp=0", outErr); end
        repeat (5) @(negedge inClk);
        checks++; if (got.size() != 0)  begin failures++; $display("FAIL reject0_no_syms got=%0d exp=0", got.size()); end
        checks++; if (err_cnt !== 1)    begin failures++; $display("FAIL reject0_err_count got=%0d exp=1", err_cnt); end
`ifdef PPDU_FCS_EN
        start_frame(126);
        checks++; if (outErr !== 1'b1)  begin failures++; $display("FAIL reject126_err got=%b exp=1", outErr); end
        checks++; if (outBusy !== 1'b0) begin failures++; $display("FAIL reject126_busy got=%b exp=0", outBusy); end
`endif
        start_frame(LEN_LEGAL);
        checks++; if (outErr !== 1'b0)  begin failures++; $display("FAIL maxlen_err got=%b exp=0", outErr); end
        checks++; if (outBusy !== 1'b1) begin failures++; $display("FAIL maxlen_busy got=%b exp=1", outBusy); end
        inRstn = 1'b0;
        @(posedge inClk); #1;
        inRstn = 1'b1;
    endtask

    task automatic test_start_during_pay();
        logic [7:0] bq[$];
        int         cyc;
        int         sz;
        bq = '{8'h11, 8'h22};
        build_exp(2, bq);
        clear_mon();
        start_frame(2);
        fork
            feed_bytes(bq, -1, 0);
            begin
                int n;
                n = 0;
                while (got.size() < 13 && n < 300) begin
                    n++;
                    @(negedge inClk);
                end
                @(posedge inClk); #1;
                inStart  = 1'b1;
                inLength = 7'd5;
                @(posedge inClk); #1;
                inStart  = 1'b0;
            end
            wait_done(400, cyc);
        join
        checks++; if (cyc < 0) begin failures++; $display("FAIL midstart_done_timeout got=%0d exp=done", cyc); end
        checks++; if (got.size() != exp.size()) begin failures++; $display("FAIL midstart_count got=%0d exp=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL midstart_sym[%0d] got=%h exp=%h", i, got[i], exp[i]); end
        end
        sz = got.size();
        repeat (4) @(negedge inClk);
        checks++; if (outBusy !== 1'b0)  begin failures++; $display("FAIL midstart_idle_busy got=%b exp=0", outBusy); end
        checks++; if (got.size() != sz)  begin failures++; $display("FAIL midstart_extra_syms got=%0d exp=%0d", got.size(), sz); end
        checks++; if (err_cnt !== 0)     begin failures++; $display("FAIL midstart_err got=%0d exp=0", err_cnt); end
        checks++; if (done_cnt !== 1)    begin failures++; $display("FAIL midstart_done_count got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        clear_mon();
        start_frame(1);
        n = 0;
        while (got.size() < 10 && n < 100) begin
            n++;
            @(negedge inClk);
        end
        checks++; if (got.size() < 10) begin failures++; $display("FAIL rstmid_reach_phr got=%0d exp=10", got.size()); end
        @(posedge inClk); #1;
        inRstn = 1'b0;
        @(posedge inClk); #1;
        inRstn = 1'b1;
        checks++; if (outSymValid !== 1'b0)  begin failures++; $display("FAIL rstmid_valid got=%b exp=0", outSymValid); end
        checks++; if (outSym !== 4'h0)       begin failures++; $display("FAIL rstmid_sym got=%h exp=0", outSym); end
        checks++; if (outByteReady !== 1'b0) begin failures++; $display("FAIL rstmid_byte_ready got=%b exp=0", outByteReady); end
        checks++; if (outBusy !== 1'b0)      begin failures++; $display("FAIL rstmid_busy got=%b exp=0", outBusy); end
        checks++; if (outErr !== 1'b0)       begin failures++; $display("FAIL rstmid_err got=%b exp=0", outErr); end
        repeat (6) @(negedge inClk);
        checks++; if (done_cnt !== 0)        begin failures++; $display("FAIL rstmid_no_done got=%0d exp=0", done_cnt); end
        test_basic_frame("after_rst");
    endtask

`ifdef PPDU_FCS_EN
    task automatic test_fcs();
        logic [7:0] bq[$];
        int         cyc;
        bq = '{8'h00};
        exp = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h7, 4'hA,
                4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        clear_mon();
        start_frame(1);
        fork
            feed_bytes(bq, -1, 0);
            wait_done(300, cyc);
        join
        checks++; if (cyc !== 20) begin failures++; $display("FAIL fcs_done_latency got=%0d exp=20", cyc); end
        checks++; if (got.size() != exp.size()) begin failures++; $display("FAIL fcs_count got=%0d exp=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checks++; if (got[i] !== exp[i]) begin failures++; $display("FAIL fcs_sym[%0d] got=%h exp=%h", i, got[i], exp[i]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_frame("basic");
        test_backpressure();
        test_underrun();
        test_reject();
        test_start_during_pay();
        test_reset_mid_frame();
`ifdef PPDU_FCS_EN
        test_fcs();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
